// File: rtl/test_nport_rand_delay_mem_pkg.sv
// Shared memory-message header for the random-delay test memory.
// Req = {type, addr, len, data}; resp = {type, len, data}, listed MSB to LSB.
package test_nport_rand_delay_mem_pkg;

    localparam int unsigned MSG_TYPE_SZ    = 1;
    localparam int unsigned MSG_LEN_SZ     = 2;
    localparam logic        MSG_TYPE_READ  = 1'b0;
    localparam logic        MSG_TYPE_WRITE = 1'b1;

    localparam int unsigned LFSR_SZ = 16;
    localparam int unsigned CNT_SZ  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RESP  = 2'd2
    } port_state_e;

    function automatic int unsigned req_sz(input int unsigned addr_sz, input int unsigned data_sz);
        return MSG_TYPE_SZ + addr_sz + MSG_LEN_SZ + data_sz;
    endfunction

    function automatic int unsigned resp_sz(input int unsigned data_sz);
        return MSG_TYPE_SZ + MSG_LEN_SZ + data_sz;
    endfunction

    function automatic int unsigned req_len_lsb(input int unsigned data_sz);
        return data_sz;
    endfunction

    function automatic int unsigned req_addr_lsb(input int unsigned data_sz);
        return data_sz + MSG_LEN_SZ;
    endfunction

    function automatic int unsigned req_type_lsb(input int unsigned addr_sz, input int unsigned data_sz);
        return data_sz + MSG_LEN_SZ + addr_sz;
    endfunction

    // Per-port seed; an all-zero state would lock the LFSR, so it is remapped.
    function automatic logic [LFSR_SZ-1:0] lfsr_seed(input logic [LFSR_SZ-1:0] base, input int unsigned idx);
        logic [LFSR_SZ-1:0] s;
        s = base ^ LFSR_SZ'(idx + 1);
        return (s == '0) ? LFSR_SZ'(1) : s;
    endfunction

    // Fibonacci step, taps 16,14,13,11.
    function automatic logic [LFSR_SZ-1:0] lfsr_next(input logic [LFSR_SZ-1:0] l);
        return {l[LFSR_SZ-2:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

endpackage

// File: rtl/test_rand_delay_port.sv
// One req/resp port: accepts a request, waits a pseudo-random number of
// cycles, strobes the memory access, then holds the response until taken.
module test_rand_delay_port
    import test_nport_rand_delay_mem_pkg::*;
#(
    parameter int unsigned p_addr_sz   = 32,
    parameter int unsigned p_data_sz   = 32,
    parameter int unsigned p_max_delay = 4,
    parameter logic [15:0] p_seed      = 16'hACE1,
    parameter int unsigned p_port_idx  = 0,
    localparam int unsigned REQ_SZ     = req_sz(p_addr_sz, p_data_sz),
    localparam int unsigned RESP_SZ    = resp_sz(p_data_sz)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_req_val,
    output logic               o_req_rdy,
    input  logic [REQ_SZ-1:0]  i_req_msg,
    output logic               o_resp_val,
    input  logic               i_resp_rdy,
    output logic [RESP_SZ-1:0] o_resp_msg,
    output logic               o_acc_c,
    output logic [REQ_SZ-1:0]  o_acc_msg,
    input  logic [p_data_sz-1:0] i_rd_data
);

    localparam int unsigned        TYPE_LSB = req_type_lsb(p_addr_sz, p_data_sz);
    localparam int unsigned        LEN_LSB  = req_len_lsb(p_data_sz);
    localparam logic [LFSR_SZ-1:0] SEED     = lfsr_seed(p_seed, p_port_idx);

    port_state_e          r_state;
    logic [CNT_SZ-1:0]    r_cnt;
    logic [LFSR_SZ-1:0]   r_lfsr;
    logic                 r_req_rdy;
    logic                 r_resp_val;
    logic [RESP_SZ-1:0]   r_resp_msg;
    logic [REQ_SZ-1:0]    r_req_msg;

    logic                 w_type;
    logic [MSG_LEN_SZ-1:0] w_len;
    logic [p_data_sz-1:0] w_resp_data;

    assign w_type      = r_req_msg[TYPE_LSB];
    assign w_len       = r_req_msg[LEN_LSB +: MSG_LEN_SZ];
    assign w_resp_data = (w_type == MSG_TYPE_WRITE) ? '0 : i_rd_data;

    // Access fires on the edge that leaves DELAY; suppressed while in reset.
    assign o_acc_c    = reset && (r_state == ST_DELAY) && (r_cnt == '0);
    assign o_acc_msg  = r_req_msg;
    assign o_req_rdy  = r_req_rdy;
    assign o_resp_val = r_resp_val;
    assign o_resp_msg = r_resp_msg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_lfsr     <= SEED;
            r_req_rdy  <= 1'b0;
            r_resp_val <= 1'b0;
            r_resp_msg <= '0;
            r_req_msg  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_val && r_req_rdy) begin
                        r_req_msg <= i_req_msg;
                        r_cnt     <= CNT_SZ'(r_lfsr % LFSR_SZ'(p_max_delay + 1));
                        r_lfsr    <= lfsr_next(r_lfsr);
                        r_req_rdy <= 1'b0;
                        r_state   <= ST_DELAY;
                    end else begin
                        r_req_rdy <= 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (r_cnt == '0) begin
                        r_resp_msg <= {w_type, w_len, w_resp_data};
                        r_resp_val <= 1'b1;
                        r_state    <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_SZ'(1);
                    end
                end
                ST_RESP: begin
                    if (i_resp_rdy) begin
                        r_resp_val <= 1'b0;
                        r_req_rdy  <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/test_nport_rand_delay_mem.sv
// Multi-port test memory with independent pseudo-random response delays.
// Reads see pre-edge contents; same-edge writes land in ascending port order.
module test_nport_rand_delay_mem
    import test_nport_rand_delay_mem_pkg::*;
#(
    parameter int unsigned p_num_ports = 2,
    parameter int unsigned p_mem_sz    = 1 << 20,
    parameter int unsigned p_addr_sz   = 32,
    parameter int unsigned p_data_sz   = 32,
    parameter int unsigned p_max_delay = 4,
    parameter logic [15:0] p_seed      = 16'hACE1,
    localparam int unsigned REQ_SZ     = req_sz(p_addr_sz, p_data_sz),
    localparam int unsigned RESP_SZ    = resp_sz(p_data_sz)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [p_num_ports-1:0]         memreq_val,
    output logic [p_num_ports-1:0]         memreq_rdy,
    input  logic [p_num_ports*REQ_SZ-1:0]  memreq_msg,
    output logic [p_num_ports-1:0]         memresp_val,
    input  logic [p_num_ports-1:0]         memresp_rdy,
    output logic [p_num_ports*RESP_SZ-1:0] memresp_msg
);

    localparam int unsigned MEM_AW   = $clog2(p_mem_sz);
    localparam int unsigned IDX_W    = MEM_AW - 2;
    localparam int unsigned WORDS    = p_mem_sz / 4;
    localparam int unsigned NB       = p_data_sz / 8;
    localparam int unsigned TYPE_LSB = req_type_lsb(p_addr_sz, p_data_sz);
    localparam int unsigned ADDR_LSB = req_addr_lsb(p_data_sz);
    localparam int unsigned LEN_LSB  = req_len_lsb(p_data_sz);

    logic [p_data_sz-1:0] m [0:WORDS-1];

    logic [p_num_ports-1:0] w_acc;
    logic [REQ_SZ-1:0]      w_acc_msg [p_num_ports];
    logic [p_data_sz-1:0]   w_rd_data [p_num_ports];
    logic [IDX_W-1:0]       w_idx     [p_num_ports];
    logic [1:0]             w_off     [p_num_ports];
    logic [MSG_LEN_SZ-1:0]  w_len     [p_num_ports];

    function automatic int unsigned num_bytes(input logic [MSG_LEN_SZ-1:0] len);
        return (len == '0) ? NB : 32'(len);
    endfunction

    // True when word lane 'lane' falls inside the access; lanes past the word end drop out.
    function automatic logic lane_hit(input int unsigned lane, input logic [1:0] off,
                                      input logic [MSG_LEN_SZ-1:0] len);
        return (lane >= 32'(off)) && ((lane - 32'(off)) < num_bytes(len));
    endfunction

    function automatic logic [p_data_sz-1:0] read_lanes(input logic [p_data_sz-1:0] word,
                                                        input logic [1:0] off,
                                                        input logic [MSG_LEN_SZ-1:0] len);
        logic [p_data_sz-1:0] data;
        data = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            if (lane_hit(b, off, len)) begin
                data[(b - 32'(off))*8 +: 8] = word[b*8 +: 8];
            end
        end
        return data;
    endfunction

    for (genvar g = 0; g < p_num_ports; g++) begin : g_port
        logic [p_addr_sz-1:0] w_addr;
        logic                 w_unused_addr;

        test_rand_delay_port #(
            .p_addr_sz  (p_addr_sz),
            .p_data_sz  (p_data_sz),
            .p_max_delay(p_max_delay),
            .p_seed     (p_seed),
            .p_port_idx (g)
        ) u_port (
            .clk       (clk),
            .reset     (reset),
            .i_req_val (memreq_val[g]),
            .o_req_rdy (memreq_rdy[g]),
            .i_req_msg (memreq_msg[g*REQ_SZ +: REQ_SZ]),
            .o_resp_val(memresp_val[g]),
            .i_resp_rdy(memresp_rdy[g]),
            .o_resp_msg(memresp_msg[g*RESP_SZ +: RESP_SZ]),
            .o_acc_c   (w_acc[g]),
            .o_acc_msg (w_acc_msg[g]),
            .i_rd_data (w_rd_data[g])
        );

        // Address bits above the memory size alias onto the same words.
        assign w_addr        = w_acc_msg[g][ADDR_LSB +: p_addr_sz];
        assign w_idx[g]      = w_addr[MEM_AW-1:2];
        assign w_off[g]      = w_addr[1:0];
        assign w_len[g]      = w_acc_msg[g][LEN_LSB +: MSG_LEN_SZ];
        assign w_rd_data[g]  = read_lanes(m[w_idx[g]], w_off[g], w_len[g]);
        assign w_unused_addr = ^w_addr;
    end

    // Later ports overwrite earlier ones on overlapping lanes.
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < p_num_ports; p++) begin
            if (w_acc[p] && (w_acc_msg[p][TYPE_LSB] == MSG_TYPE_WRITE)) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (lane_hit(b, w_off[p], w_len[p])) begin
                        m[w_idx[p]][b*8 +: 8] <= w_acc_msg[p][(b - 32'(w_off[p]))*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_test_nport_rand_delay_mem.sv
// Directed bench: dut_a is 3 ports with no delay, dut_b is 2 ports with delays 0..4.
module tb_test_nport_rand_delay_mem;

    localparam int REQ_SZ  = 67;
    localparam int RESP_SZ = 35;

    logic clk;
    logic reset;

    logic [2:0]           a_val, a_rrdy;
    logic [2:0]           a_rdy, a_rval;
    logic [3*REQ_SZ-1:0]  a_msg;
    logic [3*RESP_SZ-1:0] a_rmsg;

    logic [1:0]           b_val, b_rrdy;
    logic [1:0]           b_rdy, b_rval;
    logic [2*REQ_SZ-1:0]  b_msg;
    logic [2*RESP_SZ-1:0] b_rmsg;

    int checks;
    int failures;

    logic [15:0] lfsr_m [2];
    logic        last_type;
    logic [1:0]  last_len;

    test_nport_rand_delay_mem #(
        .p_num_ports(3), .p_mem_sz(4096), .p_addr_sz(32), .p_data_sz(32),
        .p_max_delay(0), .p_seed(16'hACE1)
    ) dut_a (
        .clk(clk), .reset(reset),
        .memreq_val(a_val), .memreq_rdy(a_rdy), .memreq_msg(a_msg),
        .memresp_val(a_rval), .memresp_rdy(a_rrdy), .memresp_msg(a_rmsg)
    );

    test_nport_rand_delay_mem #(
        .p_num_ports(2), .p_mem_sz(4096), .p_addr_sz(32), .p_data_sz(32),
        .p_max_delay(4), .p_seed(16'hACE1)
    ) dut_b (
        .clk(clk), .reset(reset),
        .memreq_val(b_val), .memreq_rdy(b_rdy), .memreq_msg(b_msg),
        .memresp_val(b_rval), .memresp_rdy(b_rrdy), .memresp_msg(b_rmsg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REQ_SZ-1:0] mk_req(input logic t, input logic [31:0] a,
                                                 input logic [1:0] l, input logic [31:0] d);
        return {t, a, l, d};
    endfunction

    function automatic logic [31:0] pat(input int i);
        return 32'hB00D0000 + 32'(i * 17 + 1);
    endfunction

    // Expected latency of the next accept on dut_b port p: (lfsr mod 5) + 1.
    task automatic draw(input int p, output int lat_exp);
        logic [15:0] s;
        s = lfsr_m[p];
        lat_exp = 32'(s % 16'd5) + 1;
        lfsr_m[p] = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endtask

    task automatic xact(input int d, input int p, input logic t, input logic [31:0] addr,
                        input logic [1:0] len, input logic [31:0] data,
                        output logic [31:0] rdata, output int lat);
        int n;
        logic [RESP_SZ-1:0] r;
        n = 0;
        while ((((d == 0) ? a_rdy[p] : b_rdy[p]) !== 1'b1) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check($sformatf("rdy_timeout_d%0d_p%0d", d, p), 64'(n), 64'(0));
        if (d == 0) begin
            a_msg[p*REQ_SZ +: REQ_SZ] = mk_req(t, addr, len, data);
            a_val[p] = 1'b1;
        end else begin
            b_msg[p*REQ_SZ +: REQ_SZ] = mk_req(t, addr, len, data);
            b_val[p] = 1'b1;
        end
        tick();
        a_val = '0;
        b_val = '0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while ((((d == 0) ? a_rval[p] : b_rval[p]) !== 1'b1) && lat < 300);
        r = (d == 0) ? a_rmsg[p*RESP_SZ +: RESP_SZ] : b_rmsg[p*RESP_SZ +: RESP_SZ];
        rdata     = r[31:0];
        last_type = r[34];
        last_len  = r[33:32];
        if (d == 0) a_rrdy[p] = 1'b1;
        else        b_rrdy[p] = 1'b1;
        tick();
        a_rrdy = '0;
        b_rrdy = '0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [RESP_SZ-1:0] held;
        int lat, exp_lat, widx;
        int hist [2][6];

        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        a_val = '0; a_rrdy = '0; a_msg = '0;
        b_val = '0; b_rrdy = '0; b_msg = '0;
        lfsr_m[0] = 16'hACE0;
        lfsr_m[1] = 16'hACE3;
        for (int p = 0; p < 2; p++) for (int v = 0; v < 6; v++) hist[p][v] = 0;

        // Reset state
        repeat (3) tick();
        check("rst_a_req_rdy",   64'(a_rdy),  64'(0));
        check("rst_a_resp_val",  64'(a_rval), 64'(0));
        check("rst_a_resp_msg",  64'(a_rmsg[63:0]), 64'(0));
        check("rst_b_req_rdy",   64'(b_rdy),  64'(0));
        check("rst_b_resp_val",  64'(b_rval), 64'(0));
        check("rst_b_resp_msg",  64'(b_rmsg[63:0]), 64'(0));
        reset = 1'b1;
        check("rel_a_rdy_before_edge", 64'(a_rdy), 64'(0));
        tick();
        check("rel_a_rdy_first_cycle", 64'(a_rdy), 64'(3'b111));
        check("rel_b_rdy_first_cycle", 64'(b_rdy), 64'(2'b11));

        // Zero-delay write then read
        xact(0, 0, 1'b1, 32'h100, 2'd0, 32'hDEADBEEF, rd, lat);
        check("wr100_lat",  64'(lat), 64'(1));
        check("wr100_type", 64'(last_type), 64'(1));
        check("wr100_data", 64'(rd), 64'(0));
        xact(0, 0, 1'b0, 32'h100, 2'd0, 32'h0, rd, lat);
        check("rd100_lat",  64'(lat), 64'(1));
        check("rd100_type", 64'(last_type), 64'(0));
        check("rd100_data", 64'(rd), 64'hDEADBEEF);

        // Subword accesses
        xact(0, 1, 1'b1, 32'h200, 2'd0, 32'h11223344, rd, lat);
        xact(0, 1, 1'b0, 32'h202, 2'd1, 32'h0, rd, lat);
        check("rd202_len1", 64'(rd), 64'h22);
        check("rd202_len",  64'(last_len), 64'(1));
        xact(0, 1, 1'b1, 32'h200, 2'd2, 32'h0000AAAA, rd, lat);
        xact(0, 1, 1'b0, 32'h200, 2'd0, 32'h0, rd, lat);
        check("rd200_after_len2", 64'(rd), 64'h1122AAAA);
        xact(0, 1, 1'b0, 32'h203, 2'd3, 32'h0, rd, lat);
        check("rd203_len3_clip", 64'(rd), 64'h11);
        xact(0, 1, 1'b0, 32'h201, 2'd2, 32'h0, rd, lat);
        check("rd201_len2", 64'(rd), 64'h22AA);
        xact(0, 1, 1'b1, 32'h203, 2'd1, 32'hFFFFFF77, rd, lat);
        xact(0, 1, 1'b0, 32'h200, 2'd0, 32'h0, rd, lat);
        check("rd200_after_byte3", 64'(rd), 64'h7722AAAA);

        // Three same-cycle writes to one word; highest port wins
        a_msg = {mk_req(1'b1, 32'h40, 2'd0, 32'd3), mk_req(1'b1, 32'h40, 2'd0, 32'd2),
                 mk_req(1'b1, 32'h40, 2'd0, 32'd1)};
        a_val = 3'b111;
        tick();
        a_val = '0;
        tick();
        check("wr40_all_val", 64'(a_rval), 64'(3'b111));
        a_rrdy = 3'b111;
        tick();
        a_rrdy = '0;
        xact(0, 0, 1'b0, 32'h40, 2'd0, 32'h0, rd, lat);
        check("rd40_port_order", 64'(rd), 64'd3);

        // Same-cycle read and write: the read sees the old word
        a_msg[0 +: REQ_SZ]      = mk_req(1'b0, 32'h40, 2'd0, 32'h0);
        a_msg[REQ_SZ +: REQ_SZ] = mk_req(1'b1, 32'h40, 2'd0, 32'd9);
        a_val = 3'b011;
        tick();
        a_val = '0;
        tick();
        check("rw40_val", 64'(a_rval), 64'(3'b011));
        check("rw40_read_old", 64'(a_rmsg[31:0]), 64'd3);
        a_rrdy = 3'b011;
        tick();
        a_rrdy = '0;
        xact(0, 2, 1'b0, 32'h40, 2'd0, 32'h0, rd, lat);
        check("rd40_after_rw", 64'(rd), 64'd9);

        // Backpressure: response held stable for 10 cycles
        a_msg[2*REQ_SZ +: REQ_SZ] = mk_req(1'b0, 32'h100, 2'd0, 32'h0);
        a_val[2] = 1'b1;
        tick();
        a_val = '0;
        tick();
        held = {1'b0, 2'd0, 32'hDEADBEEF};
        for (int k = 0; k < 10; k++) begin
            check($sformatf("hold_val_%0d", k), 64'(a_rval[2]), 64'(1));
            check($sformatf("hold_msg_%0d", k), 64'(a_rmsg[2*RESP_SZ +: RESP_SZ]), 64'(held));
            check($sformatf("hold_rdy_%0d", k), 64'(a_rdy[2]), 64'(0));
            tick();
        end
        a_rrdy[2] = 1'b1;
        tick();
        a_rrdy = '0;
        check("hold_release_val", 64'(a_rval[2]), 64'(0));
        check("hold_release_rdy", 64'(a_rdy[2]), 64'(1));

        // Random delays: preload 16 words through dut_b port 0
        for (int i = 0; i < 16; i++) begin
            draw(0, exp_lat);
            xact(1, 0, 1'b1, 32'(i * 4), 2'd0, pat(i), rd, lat);
            check($sformatf("b_pre_lat_%0d", i), 64'(lat), 64'(exp_lat));
        end
        check("b_pre_wr_data_zero", 64'(rd), 64'(0));

        for (int k = 0; k < 200; k++) begin
            for (int p = 0; p < 2; p++) begin
                widx = (k * 3 + p) % 16;
                draw(p, exp_lat);
                xact(1, p, 1'b0, 32'(widx * 4), 2'd0, 32'h0, rd, lat);
                check($sformatf("b_lat_p%0d_k%0d", p, k), 64'(lat), 64'(exp_lat));
                check($sformatf("b_range_p%0d_k%0d", p, k), 64'(lat >= 1 && lat <= 5), 64'(1));
                check($sformatf("b_data_p%0d_k%0d", p, k), 64'(rd), 64'(pat(widx)));
                if (lat >= 1 && lat <= 5) hist[p][lat]++;
            end
        end
        for (int p = 0; p < 2; p++)
            for (int v = 1; v <= 5; v++)
                check($sformatf("b_lat_seen_p%0d_v%0d", p, v), 64'(hist[p][v] > 0), 64'(1));

        // Reset while a write is pending in DELAY
        draw(0, exp_lat);
        xact(1, 0, 1'b1, 32'h300, 2'd0, 32'h5, rd, lat);
        check("b_wr300_lat", 64'(lat), 64'(exp_lat));
        b_msg[0 +: REQ_SZ] = mk_req(1'b1, 32'h300, 2'd0, 32'h99);
        b_val[0] = 1'b1;
        tick();
        b_val  = '0;
        reset  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("mid_rst_resp_val_%0d", k), 64'(b_rval), 64'(0));
        end
        check("mid_rst_req_rdy", 64'(b_rdy), 64'(0));
        check("mid_rst_resp_msg", 64'(b_rmsg[63:0]), 64'(0));
        check("mid_rst_mem300", 64'(dut_b.m[32'h300 >> 2]), 64'h5);
        reset = 1'b1;
        lfsr_m[0] = 16'hACE0;
        lfsr_m[1] = 16'hACE3;
        check("mid_rst_rdy_before_edge", 64'(b_rdy), 64'(0));
        tick();
        check("mid_rst_rdy_first_cycle", 64'(b_rdy), 64'(2'b11));
        check("mid_rst_no_late_resp", 64'(b_rval), 64'(0));

        // Memory survives reset; LFSR restarts from seed
        draw(0, exp_lat);
        xact(1, 0, 1'b0, 32'h300, 2'd0, 32'h0, rd, lat);
        check("post_rst_rd300", 64'(rd), 64'h5);
        check("post_rst_lat_reseed", 64'(lat), 64'(exp_lat));
        xact(0, 1, 1'b0, 32'h100, 2'd0, 32'h0, rd, lat);
        check("post_rst_a_rd100", 64'(rd), 64'hDEADBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/test_nport_rand_delay_mem.md
TEST_NPORT_RAND_DELAY_MEM -- requirements
Module: test_nport_rand_delay_mem

Interface
REQ-001 SHALL have parameter p_num_ports, default 2, number of independent req/resp ports, legal range 1..4.
REQ-002 SHALL have parameter p_mem_sz, default 1<<20, memory size in bytes, power of two.
REQ-003 SHALL have parameter p_addr_sz, default 32; address bits above log2(p_mem_sz) are ignored.
REQ-004 SHALL have parameter p_data_sz, default 32, data width.
REQ-005 SHALL have parameter p_max_delay, default 4, maximum random delay per request, range 0..255.
REQ-006 SHALL have parameter p_seed, default 16'hACE1, LFSR base seed.
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 reset  input  1  synchronous, active-low reset.
REQ-009 memreq_val  input  p_num_ports  per-port request valid.
REQ-010 memreq_rdy  output  p_num_ports  per-port request ready.
REQ-011 memreq_msg  input  p_num_ports*REQ_SZ  port i in slice i; fields type(1: 0=read, 1=write), addr, len(2), data.
REQ-012 memresp_val  output  p_num_ports  per-port response valid.
REQ-013 memresp_rdy  input  p_num_ports  per-port response ready.
REQ-014 memresp_msg  output  p_num_ports*RESP_SZ  port i in slice i; fields type(1), len(2), data.

Function
REQ-015 Storage SHALL be a word array named m, p_mem_sz/4 entries, indexed by addr[log2(p_mem_sz)-1:2], so the bench can load it with $readmemh.
REQ-016 Each port SHALL run an independent FSM with states IDLE, DELAY, RESP.
REQ-017 memreq_rdy[i] SHALL be 1 only in IDLE; a request is accepted when val and rdy are both 1.
REQ-018 On accept, the port SHALL latch the message, load cnt = lfsr[i] mod (p_max_delay+1), advance lfsr[i], and go to DELAY.
REQ-019 DELAY SHALL decrement cnt each cycle; when cnt==0 the access is performed and the port goes to RESP on that edge.
REQ-020 Consequence of REQ-018/019: with drawn delay d, memresp_val rises exactly d+1 cycles after the accept edge.
REQ-021 memresp_val[i] SHALL be held high with a stable message in RESP until memresp_rdy[i]; the port returns to IDLE on that edge.
REQ-022 len encoding: 0 = full word, 1..3 = byte count; lanes are selected by addr[1:0]; lanes past the word boundary are ignored.
REQ-023 Read data SHALL be zero-extended into the low bytes; write responses SHALL carry data 0.
REQ-024 For same-cycle accesses, all reads SHALL see pre-cycle contents; writes SHALL apply in ascending port order, so the highest index wins on overlap.
REQ-025 lfsr[i] SHALL be 16-bit Fibonacci, taps 16,14,13,11, seeded p_seed ^ (i+1); the seed is never zero.
REQ-026 With p_max_delay=0, every response SHALL arrive 1 cycle after accept.

Reset
REQ-027 While reset==0: all FSMs SHALL be IDLE, memreq_rdy=0, memresp_val=0, memresp_msg=0, cnt=0, and lfsr reloaded with seeds.
REQ-028 reset==0 mid-operation SHALL drop pending requests and responses without a memory write.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 memreq_rdy SHALL rise in the first cycle after reset returns to 1.

Structure
REQ-031 Message field widths, offsets, REQ_SZ/RESP_SZ and type encodings SHALL come from the shared memory-message header; no local redefinition.
REQ-032 The per-port FSM, counter and LFSR SHALL be one sub-module, test_rand_delay_port, instantiated p_num_ports times by generate loop.
REQ-033 The memory array and write-ordering logic SHALL stay in the top module.

Verification
REQ-034 p_max_delay=0, port0: write addr 0x100 data 0xDEADBEEF len 0, then read 0x100 -> write resp 1 cycle after accept, read data 0xDEADBEEF.
REQ-035 Subword: word 0x200=0x11223344; read len 1 addr 0x202 -> data 0x00000022; write len 2 addr 0x200 data 0xAAAA -> word 0x1122AAAA.
REQ-036 p_max_delay=4, 200 reads per port -> every latency in 1..5, each value seen at least once, data correct.
REQ-037 p_num_ports=3, all ports write addr 0x40 (data 1,2,3) in the same cycle -> subsequent read returns 3.
REQ-038 Hold memresp_rdy=0 for 10 cycles in RESP -> val and msg stable, memreq_rdy=0; release -> IDLE next cycle.
REQ-039 Assert reset mid-DELAY on a write to 0x300 (old value 0x5) -> no response, 0x300 still 0x5, memreq_rdy=1 first cycle after release.
